cpu_ctrl_seq: RTL and testbench

- Parametrised instruction-sequencing controller for the RISC CPU family.
- Drives the PC, IR, accumulator and memory strobes through fetch/decode/execute for each instruction.
- Over the previous fixed 8-state controller it adds:
  - configurable opcode width with extended opcodes;
  - multi-byte instruction fetch;
  - memory wait-state handshake;
  - a restartable halt.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/cpu_ctrl_seq_if.sv | 36 +++
 rtl/cpu_op_decode.sv | 33 +++
 rtl/cpu_ctrl_seq.sv | 125 ++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the instruction-sequencing controller.
// Holds the sequencer state encoding, the opcode map and the small decode helpers
// used by cpu_op_decode. Opcodes are held at 5 bits so every legal OPW fits.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StFAddr  = 4'd0,
        StFRd    = 4'd1,
        StFLd    = 4'd2,
        StFInc   = 4'd3,
        StDInc   = 4'd4,
        StEAddr  = 4'd5,
        StEOp    = 4'd6,
        StEWb    = 4'd7,
        StHalted = 4'd8
    } state_t;

    localparam logic [4:0] OpHlt = 5'd0;
    localparam logic [4:0] OpSkz = 5'd1;
    localparam logic [4:0] OpAdd = 5'd2;
    localparam logic [4:0] OpAnd = 5'd3;
    localparam logic [4:0] OpXor = 5'd4;
    localparam logic [4:0] OpLda = 5'd5;
    localparam logic [4:0] OpSto = 5'd6;
    localparam logic [4:0] OpJmp = 5'd7;
    localparam logic [4:0] OpOr  = 5'd8;
    localparam logic [4:0] OpSub = 5'd9;
    localparam logic [4:0] OpSkn = 5'd10;
    localparam logic [4:0] OpJz  = 5'd11;
    localparam logic [4:0] OpNop = 5'd12;

    // Opcodes that read memory and load the accumulator from the ALU.
    function automatic logic is_alu(input logic [4:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpXor) ||
               (op == OpLda) || (op == OpOr)  || (op == OpSub);
    endfunction

    // Extended opcodes only exist once the opcode field is at least 4 bits wide.
    function automatic logic is_legal(input logic [4:0] op, input int unsigned opw);
        return (op <= OpJmp) || ((opw >= 32'd4) && (op <= OpNop));
    endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Bus between the sequencer and the CPU datapath / memory.
// master: the controller (drives strobes, reads opcode, flags, mem_ready, resume).
// slave : the datapath side (drives opcode, flags, handshake; reads strobes).
interface cpu_ctrl_seq_if #(
    parameter int unsigned OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           neg;
    logic           mem_ready;
    logic           resume;
    logic           rd;
    logic           wr;
    logic           ld_ir;
    logic           ld_ac;
    logic           ld_pc;
    logic           inc_pc;
    logic           halt;
    logic           data_e;
    logic           sel;
    logic           ir_byte;
    logic           illegal;
    logic [3:0]     state_o;

    modport master (
        input  opcode, zero, neg, mem_ready, resume,
        output rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, ir_byte, illegal,
               state_o
    );

    modport slave (
        output opcode, zero, neg, mem_ready, resume,
        input  rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, ir_byte, illegal,
               state_o
    );
endinterface

// File: rtl/cpu_op_decode.sv
// Combinational opcode decoder.
// Inputs : opcode_i (OPW bits), zero_i, neg_i accumulator flags.
// Outputs: alu_op_o, is_sto_o, jmp_t_o (jump taken), skp_t_o (skip taken),
//          is_hlt_o, illegal_o. Illegal opcodes decode as a NOP (all other outputs 0).
module cpu_op_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW = 4
) (
    input  logic [OPW-1:0] opcode_i,
    input  logic           zero_i,
    input  logic           neg_i,
    output logic           alu_op_o,
    output logic           is_sto_o,
    output logic           jmp_t_o,
    output logic           skp_t_o,
    output logic           is_hlt_o,
    output logic           illegal_o
);
    logic [4:0] op;
    logic       legal;

    always_comb begin
        op        = 5'(opcode_i);
        legal     = is_legal(op, OPW);
        alu_op_o  = legal && is_alu(op);
        is_sto_o  = legal && (op == OpSto);
        is_hlt_o  = legal && (op == OpHlt);
        jmp_t_o   = legal && ((op == OpJmp) || ((op == OpJz) && zero_i));
        skp_t_o   = legal && (((op == OpSkz) && zero_i) || ((op == OpSkn) && neg_i));
        illegal_o = !legal;
    end
endmodule

// File: rtl/cpu_ctrl_seq.sv
// Instruction-sequencing controller: fetch (1 or 2 IR bytes), decode, execute, halt.
// Ports: clk, rst_n (async, active-low), bus (cpu_ctrl_seq_if.master) carrying opcode,
// flags, mem_ready/resume in and rd/wr/ld_*/inc_pc/halt/data_e/sel/ir_byte/illegal/
// state_o out. All strobes are combinational decodes of state, opcode and flags.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW      = 4,
    parameter int unsigned IR_BYTES = 1,
    parameter bit          WAIT_EN  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_ctrl_seq_if.master bus
);
    localparam logic LastByte = 1'(IR_BYTES - 1);

    state_t state_q, state_d;
    logic   byte_cnt_q, byte_cnt_d;
    logic   ready;
    logic   alu_op, is_sto, jmp_t, skp_t, is_hlt, op_illegal;
    logic   mem_op;

    cpu_op_decode #(
        .OPW (OPW)
    ) u_decode (
        .opcode_i  (bus.opcode),
        .zero_i    (bus.zero),
        .neg_i     (bus.neg),
        .alu_op_o  (alu_op),
        .is_sto_o  (is_sto),
        .jmp_t_o   (jmp_t),
        .skp_t_o   (skp_t),
        .is_hlt_o  (is_hlt),
        .illegal_o (op_illegal)
    );

    assign ready       = WAIT_EN ? bus.mem_ready : 1'b1;
    // Execute phases only wait on memory when the opcode actually accesses it.
    assign mem_op      = alu_op || is_sto;
    assign bus.state_o = state_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.ld_ir   = 1'b0;
        bus.ld_ac   = 1'b0;
        bus.ld_pc   = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.halt    = 1'b0;
        bus.data_e  = 1'b0;
        bus.sel     = 1'b0;
        bus.ir_byte = 1'b0;
        bus.illegal = 1'b0;

        case (state_q)
            StFAddr: begin
                bus.sel = 1'b1;
                state_d = StFRd;
            end
            StFRd: begin
                bus.sel     = 1'b1;
                bus.rd      = 1'b1;
                bus.ir_byte = byte_cnt_q;
                if (ready) state_d = StFLd;
            end
            StFLd: begin
                bus.sel     = 1'b1;
                bus.rd      = 1'b1;
                bus.ld_ir   = 1'b1;
                bus.ir_byte = byte_cnt_q;
                state_d     = (byte_cnt_q != LastByte) ? StFInc : StDInc;
            end
            StFInc: begin
                bus.sel    = 1'b1;
                bus.inc_pc = 1'b1;
                byte_cnt_d = byte_cnt_q + 1'b1;
                state_d    = StFRd;
            end
            StDInc: begin
                bus.inc_pc  = 1'b1;
                bus.halt    = is_hlt;
                bus.illegal = op_illegal;
                byte_cnt_d  = 1'b0;
                state_d     = is_hlt ? StHalted : StEAddr;
            end
            StEAddr: begin
                bus.rd  = alu_op;
                state_d = StEOp;
            end
            StEOp: begin
                bus.rd     = alu_op;
                bus.data_e = is_sto;
                bus.inc_pc = skp_t;
                if (ready || !mem_op) state_d = StEWb;
            end
            StEWb: begin
                bus.rd     = alu_op;
                // Load only on the completing cycle so a stalled read gives a single pulse.
                bus.ld_ac  = alu_op && ready;
                bus.wr     = is_sto;
                bus.data_e = is_sto;
                bus.ld_pc  = jmp_t;
                if (ready || !mem_op) state_d = StFAddr;
            end
            StHalted: begin
                bus.halt = 1'b1;
                if (bus.resume) state_d = StFAddr;
            end
            default: state_d = StFAddr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFAddr;
            byte_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: dut1 (OPW=4, IR_BYTES=1) runs directed instructions, dut2
// (OPW=4, IR_BYTES=2) loops NOPs. A queue-of-steps model tracks each DUT and is
// compared every cycle; directed literal checks pin latency and pulse counts.
module tb_cpu_ctrl_seq;
    import cpu_ctrl_pkg::*;

    localparam int RD = 10, WR = 9, LDIR = 8, LDAC = 7, LDPC = 6, INC = 5;
    localparam int HALT = 4, DE = 3, SEL = 2, IRB = 1, ILL = 0;

    typedef struct packed {
        state_t      st;
        logic [10:0] o;
        logic [1:0]  kind;   // 0: always advances, 1: waits mem_ready, 2: waits resume
    } step_t;
    typedef step_t steps_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [3:0]  drv_op[2];
    logic        drv_z[2], drv_n[2], drv_rdy[2], drv_res[2];
    logic [10:0] dout[2];
    logic [3:0]  dst[2];
    steps_t      qs[2];

    always #5 clk = ~clk;

    cpu_ctrl_seq_if #(.OPW(4)) b1 ();
    cpu_ctrl_seq_if #(.OPW(4)) b2 ();

    cpu_ctrl_seq #(.OPW(4), .IR_BYTES(1), .WAIT_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    cpu_ctrl_seq #(.OPW(4), .IR_BYTES(2), .WAIT_EN(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    assign b1.opcode = drv_op[0];
    assign b1.zero = drv_z[0];
    assign b1.neg = drv_n[0];
    assign b1.mem_ready = drv_rdy[0];
    assign b1.resume = drv_res[0];
    assign b2.opcode = drv_op[1];
    assign b2.zero = drv_z[1];
    assign b2.neg = drv_n[1];
    assign b2.mem_ready = drv_rdy[1];
    assign b2.resume = drv_res[1];
    assign dout[0] = {b1.rd, b1.wr, b1.ld_ir, b1.ld_ac, b1.ld_pc, b1.inc_pc, b1.halt,
                      b1.data_e, b1.sel, b1.ir_byte, b1.illegal};
    assign dout[1] = {b2.rd, b2.wr, b2.ld_ir, b2.ld_ac, b2.ld_pc, b2.inc_pc, b2.halt,
                      b2.data_e, b2.sel, b2.ir_byte, b2.illegal};
    assign dst[0] = b1.state_o;
    assign dst[1] = b2.state_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] bit_at(input logic c, input int pos);
        return c ? (11'd1 << pos) : 11'd0;
    endfunction

    function automatic step_t mk(input state_t st, input logic [10:0] o, input logic [1:0] k);
        step_t r;
        r.st = st;
        r.o = o;
        r.kind = k;
        return r;
    endfunction

    function automatic steps_t build_fetch(input int nb);
        steps_t s;
        s.push_back(mk(StFAddr, bit_at(1'b1, SEL), 2'd0));
        for (int b = 0; b < nb; b++) begin
            if (b > 0) s.push_back(mk(StFInc, bit_at(1'b1, SEL) | bit_at(1'b1, INC), 2'd0));
            s.push_back(mk(StFRd, bit_at(1'b1, SEL) | bit_at(1'b1, RD) | bit_at(b == 1, IRB),
                           2'd1));
            s.push_back(mk(StFLd, bit_at(1'b1, SEL) | bit_at(1'b1, RD) | bit_at(1'b1, LDIR) |
                           bit_at(b == 1, IRB), 2'd0));
        end
        return s;
    endfunction

    function automatic steps_t build_exec(input logic [3:0] op, input logic z, input logic n);
        steps_t s;
        int o = int'(op);
        logic legal = (o <= 12);
        logic hlt = (o == 0);
        logic alu = o inside {2, 3, 4, 5, 8, 9};
        logic sto = (o == 6);
        logic jmp = (o == 7) || ((o == 11) && z);
        logic skp = ((o == 1) && z) || ((o == 10) && n);
        logic [1:0] k = (alu || sto) ? 2'd1 : 2'd0;
        s.push_back(mk(StDInc, bit_at(1'b1, INC) | bit_at(hlt, HALT) | bit_at(!legal, ILL),
                       2'd0));
        if (hlt) begin
            s.push_back(mk(StHalted, bit_at(1'b1, HALT), 2'd2));
        end else begin
            s.push_back(mk(StEAddr, bit_at(alu, RD), 2'd0));
            s.push_back(mk(StEOp, bit_at(alu, RD) | bit_at(sto, DE) | bit_at(skp, INC), k));
            s.push_back(mk(StEWb, bit_at(alu, RD) | bit_at(alu, LDAC) | bit_at(sto, WR) |
                           bit_at(sto, DE) | bit_at(jmp, LDPC), k));
        end
        return s;
    endfunction

    // Model: one step consumed per clock unless the current step is waiting.
    initial forever begin
        step_t cur;
        logic  go;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            qs[0] = build_fetch(1);
            qs[1] = build_fetch(2);
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (qs[d].size() > 0) begin
                    cur = qs[d][0];
                    go = (cur.kind == 2'd0) || ((cur.kind == 2'd1) && drv_rdy[d]) ||
                         ((cur.kind == 2'd2) && drv_res[d]);
                    if (go) begin
                        qs[d].delete(0);
                        if (qs[d].size() == 0) begin
                            if (cur.st == StFLd) qs[d] = build_exec(drv_op[d], drv_z[d], drv_n[d]);
                            else qs[d] = build_fetch(d + 1);
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        logic [10:0] exp_o;
        @(negedge clk);
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                if (qs[d].size() > 0) begin
                    exp_o = qs[d][0].o;
                    if ((qs[d][0].kind == 2'd1) && !drv_rdy[d]) exp_o[LDAC] = 1'b0;
                    check($sformatf("dut%0d outputs", d + 1), 32'(dout[d]), 32'(exp_o));
                    check($sformatf("dut%0d state", d + 1), 32'(dst[d]), 32'(qs[d][0].st));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int d, input state_t st, input string name);
        int k = 0;
        while ((dst[d] != st) && (k < 40)) begin
            tick();
            k++;
        end
        check(name, 32'(dst[d]), 32'(st));
    endtask

    // Runs one instruction on dut1 starting in F_ADDR; counts cycles and pulses.
    task automatic run_instr(input logic [3:0] op, input logic z, input logic n,
                             output int cyc, output int incs, output int ldpcs,
                             output int both, output int ldac_at, output int ills);
        drv_op[0] = op;
        drv_z[0] = z;
        drv_n[0] = n;
        cyc = 1; incs = 0; ldpcs = 0; both = 0; ldac_at = 0; ills = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (dout[0][INC]) incs++;
            if (dout[0][LDPC]) ldpcs++;
            if (dout[0][INC] && dout[0][LDPC]) both++;
            if (dout[0][LDAC]) ldac_at = cyc;
            if (dout[0][ILL]) ills++;
            tick();
            if (dst[0] == StFAddr) break;
            cyc++;
        end
    endtask

    initial begin
        int cyc, incs, ldpcs, both, ldac_at, ills, cnt, hold, lds;
        logic [3:0] irb_seq;
        for (int d = 0; d < 2; d++) begin
            drv_op[d] = 4'd12;
            drv_z[d] = 1'b0;
            drv_n[d] = 1'b0;
            drv_rdy[d] = 1'b1;
            drv_res[d] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        tick();
        tick();
        check("reset outputs dut1", 32'(dout[0]), 32'h004);
        check("reset state dut1", 32'(dst[0]), 32'(StFAddr));
        check("reset outputs dut2", 32'(dout[1]), 32'h004);
        rst_n = 1'b1;

        run_instr(4'd2, 1'b0, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("add cycles", 32'(cyc), 32'd7);
        check("add inc_pc pulses", 32'(incs), 32'd1);
        check("add ld_ac cycle", 32'(ldac_at), 32'd7);

        run_instr(4'd1, 1'b1, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("skz zero=1 inc_pc pulses", 32'(incs), 32'd2);
        drv_res[0] = 1'b1;  // resume outside HALTED must be ignored
        run_instr(4'd1, 1'b0, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("skz zero=0 inc_pc pulses", 32'(incs), 32'd1);
        check("skz zero=0 cycles", 32'(cyc), 32'd7);
        drv_res[0] = 1'b0;

        run_instr(4'd11, 1'b1, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("jz zero=1 ld_pc pulses", 32'(ldpcs), 32'd1);
        check("jz inc_pc with ld_pc", 32'(both), 32'd0);
        run_instr(4'd11, 1'b0, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("jz zero=0 ld_pc pulses", 32'(ldpcs), 32'd0);

        // STO with three wait cycles in E_WB.
        drv_op[0] = 4'd6;
        wait_state(0, StEWb, "sto reach E_WB");
        drv_rdy[0] = 1'b0;
        cnt = 0;
        hold = 0;
        repeat (3) begin
            #1;
            if (dout[0][WR] && dout[0][DE]) cnt++;
            tick();
            if (dst[0] == StEWb) hold++;
        end
        drv_rdy[0] = 1'b1;
        #1;
        if (dout[0][WR] && dout[0][DE]) cnt++;
        tick();
        check("sto wr/data_e cycles", 32'(cnt), 32'd4);
        check("sto stall cycles", 32'(hold), 32'd3);
        check("sto next state", 32'(dst[0]), 32'(StFAddr));

        // Two-byte fetch on dut2.
        drv_op[0] = 4'd12;
        wait_state(1, StFAddr, "dut2 reach F_ADDR");
        cyc = 1; lds = 0; incs = 0; irb_seq = 4'd0;
        for (int i = 0; i < 40; i++) begin
            if (dout[1][LDIR]) begin
                if (lds < 4) irb_seq[lds] = dout[1][IRB];
                lds++;
            end
            if (dout[1][INC]) incs++;
            tick();
            if (dst[1] == StFAddr) break;
            cyc++;
        end
        check("2-byte nop cycles", 32'(cyc), 32'd10);
        check("2-byte ld_ir pulses", 32'(lds), 32'd2);
        check("2-byte ir_byte order", 32'(irb_seq), 32'h2);
        check("2-byte inc_pc pulses", 32'(incs), 32'd2);

        // Halt and resume.
        wait_state(0, StFAddr, "dut1 resync");
        drv_op[0] = 4'd0;
        wait_state(0, StDInc, "hlt reach D_INC");
        check("hlt halt in D_INC", 32'(dout[0][HALT]), 32'd1);
        tick();
        cnt = 0;
        repeat (20) begin
            if (dout[0][HALT] && (dst[0] == StHalted)) cnt++;
            tick();
        end
        check("halted cycles", 32'(cnt), 32'd20);
        drv_res[0] = 1'b1;
        tick();
        check("resume state", 32'(dst[0]), 32'(StFAddr));
        check("resume halt", 32'(dout[0][HALT]), 32'd0);
        drv_res[0] = 1'b0;

        run_instr(4'd14, 1'b0, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("illegal pulses", 32'(ills), 32'd1);
        check("illegal cycles", 32'(cyc), 32'd7);

        // Asynchronous reset in the middle of E_OP.
        drv_op[0] = 4'd2;
        wait_state(0, StEOp, "add reach E_OP");
        #2 rst_n = 1'b0;
        #1;
        check("mid reset outputs", 32'(dout[0]), 32'h004);
        check("mid reset state", 32'(dst[0]), 32'(StFAddr));
        tick();
        drv_op[0] = 4'd12;
        rst_n = 1'b1;
        run_instr(4'd12, 1'b0, 1'b0, cyc, incs, ldpcs, both, ldac_at, ills);
        check("post reset nop cycles", 32'(cyc), 32'd7);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
